// File: rtl/tt_sel_receiver_if.sv
// Purpose : bundle of the 3-wire design-select pads and the receiver's
//           address/status outputs for one user-design slot.
// Signals : ctrl_sel_rst_n_i, ctrl_sel_inc_i, ctrl_ena_i  - pad inputs (async)
//           sel_addr/sel_mux/sel_blk/sel_match             - address view
//           um_ena/um_rst_n                                - user design control
//           wrap/proto_err                                 - status
// Modports: slave  - the receiver (consumes pads, drives status)
//           master - the pad driver side (drives pads, observes status)
interface tt_sel_receiver_if;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned HALF_W = 5;

    logic              ctrl_sel_rst_n_i;
    logic              ctrl_sel_inc_i;
    logic              ctrl_ena_i;
    logic [ADDR_W-1:0] sel_addr;
    logic [HALF_W-1:0] sel_mux;
    logic [HALF_W-1:0] sel_blk;
    logic              sel_match;
    logic              um_ena;
    logic              um_rst_n;
    logic              wrap;
    logic              proto_err;

    modport slave (
        input  ctrl_sel_rst_n_i, ctrl_sel_inc_i, ctrl_ena_i,
        output sel_addr, sel_mux, sel_blk, sel_match,
        output um_ena, um_rst_n, wrap, proto_err
    );

    modport master (
        output ctrl_sel_rst_n_i, ctrl_sel_inc_i, ctrl_ena_i,
        input  sel_addr, sel_mux, sel_blk, sel_match,
        input  um_ena, um_rst_n, wrap, proto_err
    );
endinterface

// File: rtl/tt_sel_receiver.sv
// Purpose : mux-side receiver of the design-select protocol. Synchronises the
//           three pads, counts sel_inc rising edges into a 10-bit {mux,blk}
//           address, and on an ena rise enables and resets the user design
//           when the address equals {MUX_ID, BLK_ID}.
// Ports   : clk_a  - clock
//           rst_n  - synchronous active-low reset
//           bus    - tt_sel_receiver_if.slave (pads in, address/status out)
module tt_sel_receiver #(
    parameter int unsigned MUX_ID      = 12,
    parameter int unsigned BLK_ID      = 0,
    parameter int unsigned RST_CYCLES  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk_a,
    input  logic                rst_n,
    tt_sel_receiver_if.slave    bus
);

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned HALF_W = 5;
    localparam int unsigned CNT_W  = 8;

    localparam logic [ADDR_W-1:0] MATCH_ADDR = {HALF_W'(MUX_ID), HALF_W'(BLK_ID)};
    localparam logic [ADDR_W-1:0] ADDR_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(RST_CYCLES - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MISS    = 2'd1;
    localparam logic [1:0] ST_ACT_RST = 2'd2;
    localparam logic [1:0] ST_ACT_RUN = 2'd3;

    logic [SYNC_STAGES-1:0] rst_sync_q, rst_sync_d;
    logic [SYNC_STAGES-1:0] inc_sync_q, inc_sync_d;
    logic [SYNC_STAGES-1:0] ena_sync_q, ena_sync_d;
    logic                   inc_dly_q, inc_dly_d;
    logic                   ena_dly_q, ena_dly_d;
    logic [ADDR_W-1:0]      sel_addr_q, sel_addr_d;
    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   um_ena_q, um_ena_d;
    logic                   um_rst_n_q, um_rst_n_d;
    logic                   wrap_q, wrap_d;
    logic                   proto_err_q, proto_err_d;

    logic sel_rst_s;
    logic inc_s;
    logic ena_s;
    logic inc_rise;
    logic ena_rise;
    logic sel_match_c;

    assign sel_rst_s   = rst_sync_q[SYNC_STAGES-1];
    assign inc_s       = inc_sync_q[SYNC_STAGES-1];
    assign ena_s       = ena_sync_q[SYNC_STAGES-1];
    assign inc_rise    = inc_s & ~inc_dly_q;
    assign ena_rise    = ena_s & ~ena_dly_q;
    assign sel_match_c = (sel_addr_q == MATCH_ADDR);

    // State register
    always_ff @(posedge clk_a) begin
        if (!rst_n) begin
            rst_sync_q  <= '0;
            inc_sync_q  <= '0;
            ena_sync_q  <= '0;
            inc_dly_q   <= 1'b0;
            ena_dly_q   <= 1'b0;
            sel_addr_q  <= '0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            um_ena_q    <= 1'b0;
            um_rst_n_q  <= 1'b0;
            wrap_q      <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            rst_sync_q  <= rst_sync_d;
            inc_sync_q  <= inc_sync_d;
            ena_sync_q  <= ena_sync_d;
            inc_dly_q   <= inc_dly_d;
            ena_dly_q   <= ena_dly_d;
            sel_addr_q  <= sel_addr_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            um_ena_q    <= um_ena_d;
            um_rst_n_q  <= um_rst_n_d;
            wrap_q      <= wrap_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Synchronisers, address counter and activation FSM
    always_comb begin
        rst_sync_d  = {rst_sync_q[SYNC_STAGES-2:0], bus.ctrl_sel_rst_n_i};
        inc_sync_d  = {inc_sync_q[SYNC_STAGES-2:0], bus.ctrl_sel_inc_i};
        ena_sync_d  = {ena_sync_q[SYNC_STAGES-2:0], bus.ctrl_ena_i};
        inc_dly_d   = inc_s;
        ena_dly_d   = ena_s;
        sel_addr_d  = sel_addr_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        wrap_d      = 1'b0;
        proto_err_d = proto_err_q;

        if (!sel_rst_s) begin
            // Protocol clear overrides everything except rst_n; proto_err survives.
            sel_addr_d = '0;
            state_d    = ST_IDLE;
        end else begin
            // An increment while ena is high is a protocol violation and is dropped.
            if (inc_rise) begin
                if (ena_s) begin
                    proto_err_d = 1'b1;
                end else begin
                    sel_addr_d = sel_addr_q + ADDR_W'(1);
                    wrap_d     = (sel_addr_q == ADDR_MAX);
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (ena_rise) begin
                        if (sel_match_c) begin
                            state_d = ST_ACT_RST;
                            cnt_d   = CNT_LOAD;
                        end else begin
                            state_d = ST_MISS;
                        end
                    end
                end
                ST_MISS: begin
                    if (!ena_s) state_d = ST_IDLE;
                end
                ST_ACT_RST: begin
                    if (!ena_s) begin
                        state_d = ST_IDLE;
                    end else if (cnt_q == '0) begin
                        state_d = ST_ACT_RUN;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_ACT_RUN: begin
                    if (!ena_s) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // User-design controls are registered decodes of the next state.
        um_ena_d   = (state_d == ST_ACT_RST) || (state_d == ST_ACT_RUN);
        um_rst_n_d = (state_d == ST_ACT_RUN);
    end

    assign bus.sel_addr  = sel_addr_q;
    assign bus.sel_mux   = sel_addr_q[ADDR_W-1:HALF_W];
    assign bus.sel_blk   = sel_addr_q[HALF_W-1:0];
    assign bus.sel_match = sel_match_c;
    assign bus.um_ena    = um_ena_q;
    assign bus.um_rst_n  = um_rst_n_q;
    assign bus.wrap      = wrap_q;
    assign bus.proto_err = proto_err_q;

endmodule
